cplx_mag_est: RTL and testbench

- Pipelined complex-magnitude estimator using the alpha-max-plus-beta-min approximation: mag ≈ max(|i|,|q|) + min(|i|,|q|)/4.
- Used by the long-preamble correlator to turn the accumulated cross-correlation sum (I/Q) into a scalar peak metric.
- Throughput is one sample per clock, with a fixed latency and an aligned output strobe.

---
 rtl/cplx_mag_est_pkg.sv | 8 +
 rtl/cplx_mag_est_pipe_delay.sv | 26 ++
 rtl/cplx_mag_est.sv | 66 ++++++
 tb/tb_cplx_mag_est.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/cplx_mag_est_pkg.sv
// rtl/cplx_mag_est_pkg.sv - shared constants for the complex-magnitude estimator
package cplx_mag_est_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int MAG_LATENCY        = 3;
  localparam int BETA_SHIFT         = 2;

endpackage

// File: rtl/cplx_mag_est_pipe_delay.sv
// rtl/cplx_mag_est_pipe_delay.sv - enable-qualified shift-register delay line
module pipe_delay #(
  parameter int WIDTH = 1,
  parameter int DELAY = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] taps [DELAY];

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int k = 0; k < DELAY; k++) taps[k] <= '0;
    end else if (enable) begin
      taps[0] <= din;
      for (int k = 1; k < DELAY; k++) taps[k] <= taps[k-1];
    end
  end

  assign dout = taps[DELAY-1];

endmodule

// File: rtl/cplx_mag_est.sv
// rtl/cplx_mag_est.sv - alpha-max-plus-beta-min magnitude estimator, 3-stage pipeline
module cplx_mag_est
  import cplx_mag_est_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         enable,
  input  logic signed [DATA_WIDTH-1:0] i,
  input  logic signed [DATA_WIDTH-1:0] q,
  input  logic                         input_strobe,
  output logic        [DATA_WIDTH-1:0] mag,
  output logic                         mag_stb
);

  localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] MOST_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};

  // The most negative input has no positive counterpart, so it clamps instead of wrapping.
  function automatic logic [DATA_WIDTH-1:0] sat_abs(input logic [DATA_WIDTH-1:0] x);
    if (x == MOST_NEG)       return MOST_POS;
    else if (x[DATA_WIDTH-1]) return (~x) + 1'b1;
    else                     return x;
  endfunction

  logic [DATA_WIDTH-1:0] abs_i, abs_q;
  logic [DATA_WIDTH-1:0] mx, mn;
  logic                  stb_dly;

  always_ff @(posedge clock) begin
    if (!reset) begin
      abs_i <= '0;
      abs_q <= '0;
      mx    <= '0;
      mn    <= '0;
      mag   <= '0;
    end else if (enable) begin
      abs_i <= sat_abs(i);
      abs_q <= sat_abs(q);
      if (abs_i >= abs_q) begin
        mx <= abs_i;
        mn <= abs_q;
      end else begin
        mx <= abs_q;
        mn <= abs_i;
      end
      // mx <= 2^(W-1)-1 and mn>>2 <= 2^(W-3), so the sum fits in W bits.
      mag <= mx + (mn >> BETA_SHIFT);
    end
  end

  pipe_delay #(
    .WIDTH (1),
    .DELAY (MAG_LATENCY)
  ) u_stb_delay (
    .clock  (clock),
    .reset  (reset),
    .enable (enable),
    .din    (input_strobe),
    .dout   (stb_dly)
  );

  assign mag_stb = stb_dly;

endmodule

// File: tb/tb_cplx_mag_est.sv
// tb/tb_cplx_mag_est.sv - directed self-checking bench for cplx_mag_est
module tb_cplx_mag_est;

  logic               clock = 1'b0;
  logic               reset;
  logic               enable;
  logic signed [31:0] i;
  logic signed [31:0] q;
  logic               input_strobe;
  logic        [31:0] mag;
  logic               mag_stb;

  int checks = 0;
  int errors = 0;

  cplx_mag_est #(.DATA_WIDTH(32)) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .i            (i),
    .q            (q),
    .input_strobe (input_strobe),
    .mag          (mag),
    .mag_stb      (mag_stb)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic               stb;
    logic signed [31:0] vi;
    logic signed [31:0] vq;
    logic        [31:0] exp_mag;
  } vec_t;

  vec_t vecs [14];

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic stb, input logic signed [31:0] vi, input logic signed [31:0] vq);
    input_strobe = stb;
    i = vi;
    q = vq;
  endtask

  // Idle cycles with zero data leave mag at 0 and the strobe line empty.
  task automatic flush();
    drive(1'b0, 0, 0);
    enable = 1'b1;
    repeat (4) tick();
  endtask

  initial begin
    vecs[0]  = '{1'b1, 32'sd3, 32'sd4, 32'd4};
    vecs[1]  = '{1'b0, 32'sd0, 32'sd0, 32'd0};
    vecs[2]  = '{1'b1, -32'sd100, 32'sd40, 32'd110};
    vecs[3]  = '{1'b1, 32'sd40, -32'sd100, 32'd110};
    vecs[4]  = '{1'b1, 32'sd0, 32'sd0, 32'd0};
    vecs[5]  = '{1'b1, -32'sd8, -32'sd8, 32'd10};
    vecs[6]  = '{1'b1, 32'sh8000_0000, 32'sd0, 32'h7FFF_FFFF};
    vecs[7]  = '{1'b1, 32'sh7FFF_FFFF, 32'sh7FFF_FFFF, 32'h9FFF_FFFE};
    vecs[8]  = '{1'b1, 32'sd50, 32'sd50, 32'd62};
    vecs[9]  = '{1'b0, 32'sd77, 32'sd99, 32'd0};
    vecs[10] = '{1'b1, 32'sd1000, 32'sd0, 32'd1000};
    vecs[11] = '{1'b1, -32'sd1, -32'sd7, 32'd7};
    vecs[12] = '{1'b1, 32'sd5, -32'sd20, 32'd21};
    vecs[13] = '{1'b1, -32'sd2147483647, 32'sd1, 32'h7FFF_FFFF};

    reset = 1'b0;
    enable = 1'b1;
    drive(1'b0, 0, 0);
    repeat (2) tick();
    check("reset_mag", mag, 32'd0);
    check("reset_stb", {31'd0, mag_stb}, 32'd0);
    reset = 1'b1;

    // Streamed table: a sample driven in cycle c appears after the edge ending cycle c+2.
    for (int c = 0; c < 14 + 3; c++) begin
      if (c < 14) drive(vecs[c].stb, vecs[c].vi, vecs[c].vq);
      else        drive(1'b0, 0, 0);
      tick();
      if (c >= 2 && c - 2 < 14) begin
        check($sformatf("vec%0d_stb", c - 2), {31'd0, mag_stb}, {31'd0, vecs[c-2].stb});
        if (vecs[c-2].stb)
          check($sformatf("vec%0d_mag", c - 2), mag, vecs[c-2].exp_mag);
      end else begin
        check($sformatf("idle%0d_stb", c), {31'd0, mag_stb}, 32'd0);
      end
    end

    // Stall: 5 disabled cycles stretch the latency from 3 to 8 edges.
    flush();
    drive(1'b1, 32'sd1000, 32'sd0);
    tick();
    drive(1'b0, 0, 0);
    enable = 1'b0;
    for (int s = 0; s < 5; s++) begin
      tick();
      check($sformatf("stall%0d_stb", s), {31'd0, mag_stb}, 32'd0);
      check($sformatf("stall%0d_mag", s), mag, 32'd0);
    end
    enable = 1'b1;
    tick();
    check("stall_pre_stb", {31'd0, mag_stb}, 32'd0);
    tick();
    check("stall_out_stb", {31'd0, mag_stb}, 32'd1);
    check("stall_out_mag", mag, 32'd1000);
    enable = 1'b0;
    repeat (2) tick();
    check("hold_stb", {31'd0, mag_stb}, 32'd1);
    check("hold_mag", mag, 32'd1000);
    enable = 1'b1;
    tick();
    check("hold_release_stb", {31'd0, mag_stb}, 32'd0);

    // Reset mid-flight discards the sample already in the pipeline.
    flush();
    drive(1'b1, 32'sd50, 32'sd50);
    tick();
    drive(1'b0, 0, 0);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("midrst_mag", mag, 32'd0);
    check("midrst_stb", {31'd0, mag_stb}, 32'd0);
    for (int s = 0; s < 4; s++) begin
      tick();
      check($sformatf("midrst_drain%0d_stb", s), {31'd0, mag_stb}, 32'd0);
    end
    drive(1'b1, 32'sd50, 32'sd50);
    tick();
    drive(1'b0, 0, 0);
    check("post_rst1_stb", {31'd0, mag_stb}, 32'd0);
    tick();
    check("post_rst2_stb", {31'd0, mag_stb}, 32'd0);
    tick();
    check("post_rst3_stb", {31'd0, mag_stb}, 32'd1);
    check("post_rst3_mag", mag, 32'd62);
    tick();
    check("post_rst4_stb", {31'd0, mag_stb}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
